serial_add_ctrl: RTL and testbench

- Byte-serial multi-precision adder controller.
- Reuses one 8-bit add slice over NBYTES consecutive cycles to add two NBYTES*8-bit operands, chaining the carry through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a full-width adder.

---
 rtl/serial_add_ctrl_pkg.sv | 16 +
 rtl/serial_add_ctrl_add8.sv | 23 ++
 rtl/serial_add_ctrl.sv | 98 +++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_ctrl_pkg
// Brief   : Shared state encoding and slice width for the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package serial_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_add8.sv
`default_nettype none
// ============================================================================
// Module  : add8_cin
// Brief   : Combinational 8-bit adder slice with carry-in and carry-out.
// Revision: 1.0 - initial release
// ============================================================================
module add8_cin
    import serial_add_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    input  logic              cin,
    output logic              cout,
    output logic [BYTE_W-1:0] s
);

    logic [BYTE_W:0] w_total;

    assign w_total   = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, cin};
    assign {cout, s} = w_total;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_ctrl
// Brief   : Byte-serial multi-precision adder with valid/ready handshakes.
// Revision: 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NBYTES*BYTE_W-1:0] a,
    input  logic [NBYTES*BYTE_W-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NBYTES*BYTE_W-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int               c_width = NBYTES * BYTE_W;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(NBYTES - 1);

    logic [1:0]         r_state;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    logic [c_width-1:0] r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic [BYTE_W-1:0]  w_s;
    logic               w_c;

    add8_cin u_slice (
        .x    (r_a[BYTE_W-1:0]),
        .y    (r_b[BYTE_W-1:0]),
        .cin  (r_carry),
        .cout (w_c),
        .s    (w_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Bytes enter at the top so the first byte lands at the LSB after NBYTES shifts
                    r_sum   <= {w_s, r_sum[c_width-1:BYTE_W]};
                    r_a     <= r_a >> BYTE_W;
                    r_b     <= r_b >> BYTE_W;
                    r_carry <= w_c;
                    if (r_cnt == c_last) begin
                        r_cout  <= w_c;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_add_ctrl
// Brief   : Directed and streaming self-checking bench for serial_add_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int c_nb = 4;
    localparam int c_w  = c_nb * 8;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [c_w-1:0] a;
    logic [c_w-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [c_w-1:0] sum;
    logic           cout;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl #(.NBYTES(c_nb), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_w-1:0] va;
        logic [c_w-1:0] vb;
        logic [c_w-1:0] esum;
        logic           ecout;
        int             stall;
        logic           hold_ready;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction from an idle DUT: accept, latency, stall, handshake.
    task automatic run_txn(input vec_t v, input string name);
        int cyc;
        @(negedge clk);
        a         = v.va;
        b         = v.vb;
        in_valid  = 1'b1;
        out_ready = v.hold_ready;
        chk({name, " ready_before_accept"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '1;
        b        = '1;
        chk({name, " busy_in_run"}, {62'd0, busy, in_ready}, 64'd2);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'(c_nb + 1));
        chk({name, " result"}, {31'd0, cout, sum}, {31'd0, v.ecout, v.esum});
        if (!v.hold_ready) begin
            for (int i = 0; i < v.stall; i++) begin
                @(posedge clk);
                #1;
                chk({name, " stall_hold"}, {29'd0, in_ready, out_valid, busy, cout, sum},
                    {29'd0, 1'b0, 1'b1, 1'b1, v.ecout, v.esum});
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " back_to_idle"}, {61'd0, in_ready, out_valid, busy}, 64'd4);
    endtask

    vec_t vecs[7];

    logic [c_w-1:0] s_a[12];
    logic [c_w-1:0] s_b[12];
    logic [c_w:0]   exp_q[$];

    initial begin
        int cyc;
        int last_acc;
        int n_acc;
        int n_res;
        bit load_next;
        logic [c_w:0] e;

        vecs[0] = '{32'h0000_0012, 32'h0000_0034, 32'h0000_0046, 1'b0, 0, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0, 1'b0};
        vecs[2] = '{32'h80FF_00FF, 32'h8001_0001, 32'h0100_0100, 1'b1, 5, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0, 1'b1};
        vecs[6] = '{32'h0102_0304, 32'h1020_3040, 32'h1122_3344, 1'b0, 2, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {28'd0, in_ready, out_valid, busy, cout, sum}, {28'd0, 4'b1000, 32'd0});

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset lands on the second RUN cycle.
        @(negedge clk);
        a        = 32'h1234_5678;
        b        = 32'h1111_1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_run_reset", {28'd0, in_ready, out_valid, busy, cout, sum}, {28'd0, 4'b1000, 32'd0});
        run_txn('{32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b0}, "post_reset");

        // Streaming: in_valid held high, random out_ready.
        for (int i = 0; i < 12; i++) begin
            s_a[i] = $urandom;
            s_b[i] = $urandom;
        end
        s_a[0] = 32'hFFFF_FFFF;
        s_b[0] = 32'h0000_0001;
        n_acc     = 0;
        n_res     = 0;
        last_acc  = -100;
        load_next = 1'b1;
        cyc       = 0;
        while ((n_res < 12) && (cyc < 2000)) begin
            @(negedge clk);
            cyc++;
            if (load_next) begin
                load_next = 1'b0;
                if (n_acc < 12) begin
                    a        = s_a[n_acc];
                    b        = s_b[n_acc];
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                if (n_acc > 0) begin
                    chk("accept_spacing", 64'(((cyc - last_acc) >= (c_nb + 2)) ? 1 : 0), 64'd1);
                end
                exp_q.push_back({1'b0, a} + {1'b0, b});
                last_acc  = cyc;
                n_acc++;
                load_next = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream_result%0d", n_res), {31'd0, cout, sum}, {31'd0, e});
                end
                n_res++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_result_count", 64'(n_res), 64'd12);
        chk("stream_accept_count", 64'(n_acc), 64'd12);
        chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
